// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Executes one LDR or STR at a time against a simple request/acknowledge
// memory port and hands the result back to the register bank.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : issue strobe, honoured only while busy = 0
//   is_load         : 1 = LDR, 0 = STR (sampled with start)
//   rd              : LDR destination register index (sampled with start)
//   base            : base address (sampled with start)
//   offset          : 12-bit unsigned immediate (sampled with start)
//   up              : 1 = base + offset, 0 = base - offset (sampled with start)
//   store_data      : STR data (sampled with start)
//   mem_req/mem_we  : memory request and write qualifier
//   mem_addr        : request address
//   mem_wdata       : request write data
//   mem_ack         : memory completion
//   mem_rdata       : read data, valid in the mem_ack cycle
//   Dest, ldr_in    : register-bank writeback index and data (held between writes)
//   memory_enable   : one-cycle register-bank write strobe (LDR complete)
//   str_enable      : one-cycle store-complete pulse (STR complete)
//   busy            : high whenever the FSM is not IDLE
//   align_err       : sticky misaligned-address flag, cleared by the next start
//   timeout_err     : sticky no-acknowledge flag, cleared by the next start
//   state_dbg       : current FSM state (IDLE=0, REQ=1, WB=2, DONE=3)
//
// Memory handshake: mem_req acts as "valid" and mem_ack as "ready". A request
// is presented for as long as mem_req = 1 with mem_we/mem_addr/mem_wdata held
// constant; it completes in the first cycle where mem_req = 1 and mem_ack = 1,
// and mem_req drops on the following cycle. mem_ack is ignored while mem_req = 0.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [3:0]  rd,
  input  logic [31:0] base,
  input  logic [11:0] offset,
  input  logic        up,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  Dest,
  output logic [31:0] ldr_in,
  output logic        memory_enable,
  output logic        str_enable,
  output logic        busy,
  output logic        align_err,
  output logic        timeout_err,
  output logic [1:0]  state_dbg
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic        we_q;
  logic [3:0]  rd_q;
  logic [31:0] addr_calc;
  logic        addr_ok;
  logic        cnt_hit;

  // Offset is zero-extended; the 32-bit result wraps silently.
  assign addr_calc = up ? (base + {20'b0, offset}) : (base - {20'b0, offset});
  assign addr_ok   = (addr_calc[1:0] == 2'b00);

  // True in the REQ cycle that would make the no-ack count reach TIMEOUT.
  // An ack in that same cycle still wins, because the ack is tested first.
  assign cnt_hit = ((cnt + 8'd1) == TIMEOUT_C);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && addr_ok) state_next = REQ;
      REQ: begin
        if (mem_ack)      state_next = we_q ? DONE : WB;
        else if (cnt_hit) state_next = IDLE;
      end
      WB:      state_next = IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      we_q        <= 1'b0;
      rd_q        <= 4'd0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      Dest        <= 4'd0;
      ldr_in      <= 32'd0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            we_q        <= ~is_load;
            rd_q        <= rd;
            mem_addr    <= addr_calc;
            mem_wdata   <= store_data;
            cnt         <= 8'd0;
            timeout_err <= 1'b0;
            align_err   <= ~addr_ok;
          end
        end
        REQ: begin
          if (mem_ack) begin
            // Writeback registers change only on a load completion so they
            // hold their previous contents at all other times.
            if (!we_q) begin
              Dest   <= rd_q;
              ldr_in <= mem_rdata;
            end
          end else if (cnt_hit) begin
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // All control outputs decode the registered state, so reset clears them.
  assign mem_req       = (state == REQ);
  assign mem_we        = (state == REQ) && we_q;
  assign memory_enable = (state == WB);
  assign str_enable    = (state == DONE);
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit: directed vector table, randomized
// operations checked against a reference model, and hand-written reset
// sequences.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_load;
  logic [3:0]  rd;
  logic [31:0] base;
  logic [11:0] offset;
  logic        up;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  dest;
  logic [31:0] ldr_in;
  logic        memory_enable;
  logic        str_enable;
  logic        busy;
  logic        align_err;
  logic        timeout_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected writeback data, in issue order.
  logic [31:0] exp_q[$];
  logic [3:0]  last_dest;
  logic [31:0] last_data;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_load      (is_load),
    .rd           (rd),
    .base         (base),
    .offset       (offset),
    .up           (up),
    .store_data   (store_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .Dest         (dest),
    .ldr_in       (ldr_in),
    .memory_enable(memory_enable),
    .str_enable   (str_enable),
    .busy         (busy),
    .align_err    (align_err),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  typedef struct {
    logic        is_load;
    logic [3:0]  rd;
    logic [31:0] base;
    logic [11:0] offset;
    logic        up;
    logic [31:0] sdata;
    int          ack_delay;   // ack in REQ cycle number ack_delay+1
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_align;
    logic        exp_to;
    int          exp_req;     // number of cycles mem_req is high
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [3:0] r, input logic [31:0] b,
                              input logic [11:0] o, input logic u, input logic [31:0] sd,
                              input int dly, input logic [31:0] rdat, input logic [31:0] ea,
                              input logic eal, input logic eto, input int ereq);
    vec_t v;
    v.is_load = ld; v.rd = r; v.base = b; v.offset = o; v.up = u; v.sdata = sd;
    v.ack_delay = dly; v.rdata = rdat; v.exp_addr = ea; v.exp_align = eal;
    v.exp_to = eto; v.exp_req = ereq;
    return v;
  endfunction

  // Reference model: effective address with 2^32 wrap, alignment, and the
  // outcome of a memory that answers after ack_delay waiting cycles.
  function automatic vec_t model(input vec_t vin);
    vec_t v = vin;
    longint a;
    if (v.up) a = longint'(v.base) + longint'(v.offset);
    else      a = longint'(v.base) - longint'(v.offset) + 64'h1_0000_0000;
    v.exp_addr  = 32'(a % 64'h1_0000_0000);
    v.exp_align = (v.exp_addr % 4) != 0;
    v.exp_to    = !v.exp_align && (v.ack_delay >= TIMEOUT);
    v.exp_req   = v.exp_align ? 0 : (v.exp_to ? TIMEOUT : v.ack_delay + 1);
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; is_load = 1'b0; rd = 4'd0; base = 32'd0;
    offset = 12'd0; up = 1'b0; store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    last_dest = 4'd0;
    last_data = 32'd0;
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int   cyc = 1;
    int   req_n = 0;
    int   first_req = -1;
    int   strobe_cyc = -1;
    int   n_men = 0;
    int   n_sen = 0;
    logic req_bad = 1'b0;
    logic hold_bad = 1'b0;
    logic both_bad = 1'b0;
    logic succ = !v.exp_align && !v.exp_to;
    if (succ && v.is_load) exp_q.push_back(v.rdata);
    is_load = v.is_load; rd = v.rd; base = v.base; offset = v.offset;
    up = v.up; store_data = v.sdata; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " align_err"}, 32'(align_err), 32'(v.exp_align));
    check({tag, " busy_c1"}, 32'(busy), 32'(!v.exp_align));
    while (busy && cyc < 400) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (first_req < 0) first_req = cyc;
        if (mem_addr !== v.exp_addr || mem_we !== !v.is_load ||
            (!v.is_load && mem_wdata !== v.sdata)) req_bad = 1'b1;
        mem_ack   = (req_n == v.ack_delay);
        mem_rdata = mem_ack ? v.rdata : $urandom;
        req_n++;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (memory_enable && str_enable) both_bad = 1'b1;
      if (memory_enable) begin
        n_men++;
        strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          check({tag, " unexpected_wb"}, 32'(memory_enable), 32'd0);
        end else begin
          last_data = exp_q.pop_front();
          last_dest = v.rd;
          check({tag, " ldr_in"}, ldr_in, last_data);
          check({tag, " Dest"}, 32'(dest), 32'(last_dest));
        end
      end else if (dest !== last_dest || ldr_in !== last_data) begin
        hold_bad = 1'b1;
      end
      if (str_enable) begin
        n_sen++;
        strobe_cyc = cyc;
      end
      // Collision: garbage start while busy must be ignored.
      start = ($urandom_range(0, 3) == 0);
      base  = $urandom; is_load = 1'($urandom); rd = 4'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    mem_ack = 1'b0;
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " busy_fall_cycle"}, 32'(cyc),
          32'(v.exp_align ? 1 : (v.exp_to ? TIMEOUT + 1 : v.exp_req + 2)));
    check({tag, " req_cycles"}, 32'(req_n), 32'(v.exp_req));
    check({tag, " first_req"}, 32'(first_req), v.exp_align ? 32'hFFFF_FFFF : 32'd1);
    check({tag, " req_fields"}, 32'(req_bad), 32'd0);
    check({tag, " mem_en_count"}, 32'(n_men), 32'(succ && v.is_load));
    check({tag, " str_en_count"}, 32'(n_sen), 32'(succ && !v.is_load));
    check({tag, " strobe_cycle"}, 32'(strobe_cyc), succ ? 32'(v.exp_req + 1) : 32'hFFFF_FFFF);
    check({tag, " strobe_overlap"}, 32'(both_bad), 32'd0);
    check({tag, " wb_hold"}, 32'(hold_bad), 32'd0);
    check({tag, " timeout_err"}, 32'(timeout_err), 32'(v.exp_to));
    check({tag, " align_err_end"}, 32'(align_err), 32'(v.exp_align));
    check({tag, " Dest_end"}, 32'(dest), 32'(last_dest));
    check({tag, " ldr_in_end"}, ldr_in, last_data);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " Dest"}, 32'(dest), 32'd0);
    check({tag, " ldr_in"}, ldr_in, 32'd0);
    check({tag, " memory_enable"}, 32'(memory_enable), 32'd0);
    check({tag, " str_enable"}, 32'(str_enable), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " align_err"}, 32'(align_err), 32'd0);
    check({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[10];

  initial begin
    tbl[0] = mk(1, 4'd3, 32'h0000_0100, 12'd4,     1, 32'h0,  0,  32'hDEAD_BEEF, 32'h0000_0104, 0, 0, 1);
    tbl[1] = mk(0, 4'd0, 32'h0000_0200, 12'd8,     0, 32'h55, 2,  32'h0,         32'h0000_01F8, 0, 0, 3);
    tbl[2] = mk(1, 4'd1, 32'h0000_0102, 12'd0,     1, 32'h0,  0,  32'h1234_5678, 32'h0000_0102, 1, 0, 0);
    tbl[3] = mk(1, 4'd7, 32'h0000_0040, 12'd0,     1, 32'h0,  99, 32'h0,         32'h0000_0040, 0, 1, 15);
    tbl[4] = mk(0, 4'd0, 32'h0000_0010, 12'd4,     1, 32'hA5, 1,  32'h0,         32'h0000_0014, 0, 0, 2);
    tbl[5] = mk(1, 4'd9, 32'hFFFF_FFFC, 12'd8,     1, 32'h0,  3,  32'hCAFE_F00D, 32'h0000_0004, 0, 0, 4);
    tbl[6] = mk(0, 4'd0, 32'h0000_0000, 12'd4,     0, 32'h77, 14, 32'h0,         32'hFFFF_FFFC, 0, 0, 15);
    tbl[7] = mk(1, 4'd2, 32'h0000_1000, 12'hFFF,   1, 32'h0,  0,  32'h0,         32'h0000_1FFF, 1, 0, 0);
    tbl[8] = mk(1, 4'hF, 32'h0000_1000, 12'hFFC,   0, 32'h0,  0,  32'h0BAD_CAFE, 32'h0000_0004, 0, 0, 1);
    tbl[9] = mk(1, 4'd5, 32'h0000_0300, 12'd0,     1, 32'h0,  15, 32'h0,         32'h0000_0300, 0, 1, 15);

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.is_load   = 1'($urandom);
      v.rd        = 4'($urandom);
      v.base      = $urandom;
      v.offset    = 12'($urandom);
      v.up        = 1'($urandom);
      v.sdata     = $urandom;
      v.ack_delay = $urandom_range(0, 20);
      v.rdata     = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        v.base[1:0]   = 2'b00;
        v.offset[1:0] = 2'b00;
      end
      run_op($sformatf("rand%0d", i), model(v));
    end

    // Reset in the second REQ cycle aborts with no strobe.
    is_load = 1'b1; rd = 4'd6; base = 32'h0000_0800; offset = 12'd0; up = 1'b1;
    store_data = 32'h0; start = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("midreq c1 mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    check("midreq c2 mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b0;
    check_all_zero("midreq");
    begin
      int wb_seen = 0;
      for (int c = 0; c < 5; c++) begin
        if (memory_enable || str_enable || busy) wb_seen++;
        @(posedge clk); #1;
      end
      check("midreq no_strobe", 32'(wb_seen), 32'd0);
    end
    last_dest = 4'd0;
    last_data = 32'd0;

    // Reset takes priority over a simultaneous start.
    is_load = 1'b0; base = 32'h0000_0400; offset = 12'd0; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    check("rst_vs_start busy", 32'(busy), 32'd0);
    check("rst_vs_start mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check("rst_vs_start busy_after", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the number of REQ cycles without mem_ack before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  issue strobe; sampled only while busy=0.
REQ-005 SHALL have port is_load  input  1  1=LDR, 0=STR; sampled with start.
REQ-006 SHALL have port rd  input  4  destination register index for LDR; sampled with start.
REQ-007 SHALL have port base  input  32  base address (register-bank Result_1); sampled with start.
REQ-008 SHALL have port offset  input  12  unsigned immediate; sampled with start.
REQ-009 SHALL have port up  input  1  1=base+offset, 0=base-offset; sampled with start.
REQ-010 SHALL have port store_data  input  32  STR data (register-bank Result_2); sampled with start.
REQ-011 SHALL have port mem_req  output  1  memory request, held until ack or abort.
REQ-012 SHALL have port mem_we  output  1  1=write request; valid while mem_req=1.
REQ-013 SHALL have port mem_addr  output  32  request address.
REQ-014 SHALL have port mem_wdata  output  32  write data.
REQ-015 SHALL have port mem_ack  input  1  memory completion, valid only while mem_req=1.
REQ-016 SHALL have port mem_rdata  input  32  read data, valid in the mem_ack cycle.
REQ-017 SHALL have port Dest  output  4  writeback register index to the register bank.
REQ-018 SHALL have port ldr_in  output  32  writeback data to the register bank.
REQ-019 SHALL have port memory_enable  output  1  one-cycle register-bank write strobe.
REQ-020 SHALL have port str_enable  output  1  one-cycle store-complete pulse.
REQ-021 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-022 SHALL have port align_err  output  1  sticky misaligned-address flag.
REQ-023 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-024 SHALL implement the states IDLE, REQ, WB and DONE, registered, with busy = (state != IDLE).
REQ-025 In IDLE with start=1, SHALL latch all operands and clear both error flags.
REQ-026 SHALL compute the address as base ± zero-extended offset, modulo 2^32, wrapping without error.
REQ-027 If address[1:0] != 0, SHALL set align_err, issue no request, and stay in IDLE.
REQ-028 If the address is aligned, SHALL move to REQ next cycle with mem_req=1, mem_we=!is_load, and mem_addr/mem_wdata stable until leaving REQ.
REQ-029 In REQ with mem_ack=1: if LDR, SHALL capture mem_rdata and go to WB; if STR, SHALL go to DONE; mem_req drops the next cycle.
REQ-030 In WB, SHALL assert memory_enable for exactly one cycle with Dest=latched rd and ldr_in=captured data, then go to IDLE.
REQ-031 In DONE, SHALL assert str_enable for exactly one cycle, then go to IDLE.
REQ-032 Minimum latency: start at cycle 0 with ack at cycle 1 gives a strobe at cycle 2 and busy=0 at cycle 3.
REQ-033 SHALL count REQ cycles without ack using an 8-bit counter; when the count reaches TIMEOUT, SHALL drop mem_req, set timeout_err, produce no strobe, and go to IDLE.
REQ-034 mem_ack arriving in the same cycle the count reaches TIMEOUT SHALL count as success.
REQ-035 SHALL ignore start while busy=1, and SHALL ignore mem_ack outside REQ.
REQ-036 memory_enable and str_enable SHALL never both be high, and SHALL never be high outside WB/DONE.
REQ-037 Dest and ldr_in SHALL hold their last values when memory_enable=0.

Reset
REQ-038 When reset=1 at a clock edge, SHALL go to IDLE and clear the counter.
REQ-039 When reset=1 at a clock edge, SHALL set mem_req, mem_we, memory_enable, str_enable, busy, align_err and timeout_err to 0.
REQ-040 When reset=1 at a clock edge, SHALL set mem_addr, mem_wdata, Dest and ldr_in to 0.
REQ-041 Reset during REQ/WB/DONE SHALL abort the operation with no strobe; reset SHALL take priority over start and mem_ack.

Verification
REQ-042 LDR: base=0x100, offset=4, up=1, rd=3, ack at first REQ cycle with rdata=0xDEADBEEF -> mem_addr=0x104, mem_we=0; cycle 2 memory_enable=1, Dest=3, ldr_in=0xDEADBEEF.
REQ-043 STR: base=0x200, offset=8, up=0, store_data=0x55, ack after 3 REQ cycles -> mem_addr=0x1F8, mem_we=1, mem_wdata=0x55 stable; one str_enable pulse; memory_enable stays 0.
REQ-044 Misaligned: base=0x102, offset=0 -> align_err=1 next cycle, mem_req never asserted, busy stays 0.
REQ-045 Timeout: TIMEOUT=15, no ack -> mem_req high for 15 cycles then 0, timeout_err=1, no strobe; a following good start clears timeout_err.
REQ-046 Wrap and collision: base=0xFFFFFFFC, offset=8, up=1 -> mem_addr=0x00000004; start pulsed during REQ is ignored.
REQ-047 Reset mid-REQ: reset=1 in the 2nd REQ cycle -> all outputs 0 next cycle, no memory_enable.
